// File: rtl/lane_queue_pkg.sv
// Shared game definitions for the lane queue: lane width, lane type and the
// queue occupancy state encoding.
package lane_queue_pkg;

    localparam int LANE_W = 2;

    typedef logic [LANE_W-1:0] lane_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2
    } qstate_t;

    // Even parity over one lane value, for protecting stored lane data.
    function automatic logic lane_parity(input lane_t lane);
        return ^lane;
    endfunction

endpackage : lane_queue_pkg

// File: rtl/lane_queue_repeat_filter.sv
// Repeat filter: remembers the last pushed lane and how many times in a row it
// was pushed, and refuses a candidate that would extend the run past
// MAX_REPEAT. The run tracks push history only; pops never touch it.
module repeat_filter
    import lane_queue_pkg::*;
#(
    parameter int MAX_REPEAT = 2
) (
    input  logic  dclk,
    input  logic  rst,
    input  lane_t num_in,
    input  logic  try_push,
    input  logic  clr,
    output logic  accept
);

    localparam int RUN_W = (MAX_REPEAT > 0) ? $clog2(MAX_REPEAT + 1) : 1;

    lane_t            last_lane_r;
    logic [RUN_W-1:0] run_len_r;
    logic             same_s;
    logic             accept_s;

    // Decide whether the current candidate may be pushed this cycle.
    always_comb begin
        same_s   = (num_in == last_lane_r);
        accept_s = 1'b0;
        if (try_push && !(same_s && (run_len_r == RUN_W'(MAX_REPEAT)))) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    assign accept = accept_s;

    // Track the last pushed lane and the length of its current run.
    always_ff @(posedge dclk or negedge rst) begin
        if (!rst) begin
            last_lane_r <= lane_t'(2'd0);
            run_len_r   <= RUN_W'(0);
        end else if (clr) begin
            // last_lane is kept; a zero run length makes it irrelevant.
            run_len_r <= RUN_W'(0);
        end else if (accept_s) begin
            last_lane_r <= num_in;
            if (same_s && (run_len_r != RUN_W'(0))) begin
                run_len_r <= run_len_r + RUN_W'(1);
            end else begin
                run_len_r <= RUN_W'(1);
            end
        end else begin
            run_len_r <= run_len_r;
        end
    end

endmodule : repeat_filter

// File: rtl/lane_queue.sv
// Lane queue: samples the random lane stream into a small circular queue,
// filtering long runs of identical lanes, and serves lane choices to the
// spawn logic plus a preview of the upcoming lanes to the display.
module lane_queue
    import lane_queue_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int MAX_REPEAT = 2
) (
    input  logic                     dclk,
    input  logic                     rst,
    input  logic [LANE_W-1:0]        num_in,
    input  logic                     en,
    input  logic                     clr,
    input  logic                     pop,
    output logic [LANE_W-1:0]        lane_out,
    output logic                     lane_valid,
    output logic [LANE_W*DEPTH-1:0]  preview,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    lane_t            entries_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    qstate_t          state_r;

    logic             try_push_s;
    logic             push_s;
    logic             pop_s;
    logic [PTR_W-1:0] pidx_s;
    lane_t            lane_out_s;
    logic [LANE_W*DEPTH-1:0] preview_s;

    // Eligibility uses the pre-edge state, so a full queue never pushes even
    // when it is popped in the same cycle.
    always_comb begin
        try_push_s = en && !clr && (state_r != FULL);
        pop_s      = pop && !clr && (count_r != CNT_W'(0));
    end

    repeat_filter #(
        .MAX_REPEAT (MAX_REPEAT)
    ) u_filter (
        .dclk     (dclk),
        .rst      (rst),
        .num_in   (num_in),
        .try_push (try_push_s),
        .clr      (clr),
        .accept   (push_s)
    );

    // Occupancy state machine; follows count and is flushed by clr.
    always_ff @(posedge dclk or negedge rst) begin
        if (!rst) begin
            state_r <= EMPTY;
        end else if (clr) begin
            state_r <= EMPTY;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (push_s) state_r <= FILL;
                    else        state_r <= EMPTY;
                end
                FILL: begin
                    if (push_s && !pop_s && (count_r == CNT_W'(DEPTH - 1)))
                        state_r <= FULL;
                    else if (pop_s && !push_s && (count_r == CNT_W'(1)))
                        state_r <= EMPTY;
                    else
                        state_r <= FILL;
                end
                FULL: begin
                    if (pop_s) state_r <= FILL;
                    else       state_r <= FULL;
                end
                default: state_r <= EMPTY;
            endcase
        end
    end

    // Read/write pointers and entry count; pointers wrap modulo DEPTH.
    always_ff @(posedge dclk or negedge rst) begin
        if (!rst) begin
            rd_ptr_r <= PTR_W'(0);
            wr_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else if (clr) begin
            rd_ptr_r <= PTR_W'(0);
            wr_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            else        wr_ptr_r <= wr_ptr_r;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            else        rd_ptr_r <= rd_ptr_r;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage: written at the tail on push, zeroed on reset and flush.
    always_ff @(posedge dclk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) entries_r[i] <= lane_t'(2'd0);
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) entries_r[i] <= lane_t'(2'd0);
        end else if (push_s) begin
            entries_r[wr_ptr_r] <= num_in;
        end else begin
            entries_r[wr_ptr_r] <= entries_r[wr_ptr_r];
        end
    end

    // Head entry and head-relative preview, driven from registers only.
    always_comb begin
        lane_out_s = lane_t'(2'd0);
        preview_s  = {(LANE_W*DEPTH){1'b0}};
        pidx_s     = rd_ptr_r;
        if (count_r != CNT_W'(0)) begin
            lane_out_s = entries_r[rd_ptr_r];
        end else begin
            lane_out_s = lane_t'(2'd0);
        end
        for (int i = 0; i < DEPTH; i++) begin
            pidx_s = rd_ptr_r + PTR_W'(i);
            if (CNT_W'(i) < count_r) begin
                preview_s[LANE_W*i +: LANE_W] = entries_r[pidx_s];
            end else begin
                preview_s[LANE_W*i +: LANE_W] = lane_t'(2'd0);
            end
        end
    end

    assign lane_out   = lane_out_s;
    assign preview    = preview_s;
    assign count      = count_r;
    assign lane_valid = (count_r != CNT_W'(0));
    assign full       = (state_r == FULL);

endmodule : lane_queue

// File: tb/tb_lane_queue.sv
// Directed self-checking bench for lane_queue (DEPTH=4, MAX_REPEAT=2).
module tb_lane_queue;

    logic       dclk;
    logic       rst;
    logic [1:0] num_in;
    logic       en;
    logic       clr;
    logic       pop;
    logic [1:0] lane_out;
    logic       lane_valid;
    logic [7:0] preview;
    logic [2:0] count;
    logic       full;

    int n_checks;
    int n_fails;

    lane_queue #(
        .DEPTH      (4),
        .MAX_REPEAT (2)
    ) dut (
        .dclk       (dclk),
        .rst        (rst),
        .num_in     (num_in),
        .en         (en),
        .clr        (clr),
        .pop        (pop),
        .lane_out   (lane_out),
        .lane_valid (lane_valid),
        .preview    (preview),
        .count      (count),
        .full       (full)
    );

    initial dclk = 1'b0;
    always #5 dclk = ~dclk;

    // Compare one observed value against its expected value.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Let n rising edges pass, returning at the following falling edge.
    task automatic step(input int n);
        repeat (n) @(posedge dclk);
        @(negedge dclk);
    endtask

    // Push a list of lane values, one per cycle, then stop filling.
    task automatic push4(input logic [1:0] a, input logic [1:0] b,
                         input logic [1:0] c, input logic [1:0] d);
        en = 1'b1;
        num_in = a; step(1);
        num_in = b; step(1);
        num_in = c; step(1);
        num_in = d; step(1);
        en = 1'b0;
    endtask

    // One-cycle synchronous flush.
    task automatic flush();
        clr = 1'b1; step(1);
        clr = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst = 1'b0; num_in = 2'd0; en = 1'b0; clr = 1'b0; pop = 1'b0;
        step(2);
        check_eq("rst_count",   32'(count),      32'd0);
        check_eq("rst_valid",   32'(lane_valid), 32'd0);
        check_eq("rst_preview", 32'(preview),    32'd0);
        check_eq("rst_full",    32'(full),       32'd0);
        check_eq("rst_lane",    32'(lane_out),   32'd0);
        rst = 1'b1;
        step(1);

        // 1: fill with 1,2,3,0
        push4(2'd1, 2'd2, 2'd3, 2'd0);
        check_eq("t1_full",    32'(full),     32'd1);
        check_eq("t1_count",   32'(count),    32'd4);
        check_eq("t1_preview", 32'(preview),  32'b00_11_10_01);
        check_eq("t1_lane",    32'(lane_out), 32'd1);
        // full queue ignores further sampling
        en = 1'b1; num_in = 2'd1; step(1); en = 1'b0;
        check_eq("t1_nopush", 32'(count), 32'd4);

        // 3: pop from full while offering 2; refill happens a cycle later
        en = 1'b1; num_in = 2'd2; pop = 1'b1; step(1);
        pop = 1'b0;
        check_eq("t3_count_a", 32'(count),    32'd3);
        check_eq("t3_lane_a",  32'(lane_out), 32'd2);
        check_eq("t3_full_a",  32'(full),     32'd0);
        step(1);
        en = 1'b0;
        check_eq("t3_count_b",   32'(count),   32'd4);
        check_eq("t3_preview_b", 32'(preview), 32'b10_00_11_10);

        // 2: held value 2 is capped at two in a row, then 3 is accepted
        flush();
        check_eq("t2_flush_count", 32'(count), 32'd0);
        en = 1'b1; num_in = 2'd2; step(3);
        check_eq("t2_count",   32'(count),   32'd2);
        check_eq("t2_preview", 32'(preview), 32'b00_00_10_10);
        num_in = 2'd3; step(1); en = 1'b0;
        check_eq("t2_count_b",   32'(count),   32'd3);
        check_eq("t2_preview_b", 32'(preview), 32'b00_11_10_10);
        check_eq("t2_valid",     32'(lane_valid), 32'd1);

        // 4: simultaneous pop and push at count=2
        flush();
        en = 1'b1; num_in = 2'd1; step(1);
        num_in = 2'd2; step(1);
        num_in = 2'd3; pop = 1'b1; step(1);
        en = 1'b0; pop = 1'b0;
        check_eq("t4_count",   32'(count),    32'd2);
        check_eq("t4_lane",    32'(lane_out), 32'd2);
        check_eq("t4_preview", 32'(preview),  32'b00_00_11_10);

        // 5: pop on empty, then clr during a push resets the run
        flush();
        pop = 1'b1; step(1); pop = 1'b0;
        check_eq("t5_count", 32'(count),      32'd0);
        check_eq("t5_valid", 32'(lane_valid), 32'd0);
        check_eq("t5_lane",  32'(lane_out),   32'd0);
        en = 1'b1; num_in = 2'd1; step(1);
        check_eq("t5_ptr_lane",  32'(lane_out), 32'd1);
        check_eq("t5_ptr_count", 32'(count),    32'd1);
        step(1);
        clr = 1'b1; step(1); clr = 1'b0;
        check_eq("t5_clr_count",   32'(count),   32'd0);
        check_eq("t5_clr_preview", 32'(preview), 32'd0);
        step(3);
        check_eq("t5_rerun_count",   32'(count),   32'd2);
        check_eq("t5_rerun_preview", 32'(preview), 32'b00_00_01_01);

        // 6: async reset between edges with count=3
        num_in = 2'd3; step(1); en = 1'b0;
        check_eq("t6_pre_count", 32'(count), 32'd3);
        #2 rst = 1'b0;
        #1;
        check_eq("t6_count",   32'(count),   32'd0);
        check_eq("t6_preview", 32'(preview), 32'd0);
        check_eq("t6_full",    32'(full),    32'd0);
        step(1);
        rst = 1'b1;
        step(1);
        push4(2'd1, 2'd2, 2'd3, 2'd0);
        check_eq("t6_refill_full",    32'(full),    32'd1);
        check_eq("t6_refill_preview", 32'(preview), 32'b00_11_10_01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_lane_queue
